// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, LSB first, mid-bit sampling, framing-error strobe.
// Define UART_RX_PARITY_EN for an even-parity bit after data bit 7 and an o_rx_parity_err strobe.
module uart_receiver #(
    parameter int clks_per_bit = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_rx_parity_err,
`endif
    output logic       o_rx_busy
);
    localparam int CW = $clog2(clks_per_bit);
    localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);
    localparam logic [CW-1:0] HALF = CW'((clks_per_bit - 1) / 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        r_state, w_next;
    logic [CW-1:0] r_count, w_count;
    logic [2:0]    r_index, w_index;
    logic [7:0]    r_shift, w_shift;
    logic [7:0]    r_data, w_data;
    logic          r_valid, w_valid;
    logic          r_ferr, w_ferr;
    logic          r_rx_m, r_rx_s, r_prev;
    logic          w_par_bad;
`ifdef UART_RX_PARITY_EN
    logic          r_par, w_par;
    logic          r_perr, w_perr;
    assign w_par_bad       = ^{r_shift, r_par};
    assign o_rx_parity_err = r_perr;
`else
    assign w_par_bad = 1'b0;
`endif

    assign o_rx_data      = r_data;
    assign o_rx_valid     = r_valid;
    assign o_rx_frame_err = r_ferr;
    assign o_rx_busy      = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_index <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_rx_m  <= 1'b1;
            r_rx_s  <= 1'b1;
            r_prev  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_count <= w_count;
            r_index <= w_index;
            r_shift <= w_shift;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
            r_rx_m  <= i_rx;
            r_rx_s  <= r_rx_m;
            r_prev  <= r_rx_s;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par;
            r_perr  <= w_perr;
`endif
        end
    end

    always_comb begin
        w_next  = r_state;
        w_count = r_count + 1'b1;
        w_index = r_index;
        w_shift = r_shift;
        w_data  = r_data;
        w_valid = 1'b0;
        w_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par   = r_par;
        w_perr  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_count = '0;
                w_index = '0;
                w_next  = (r_prev && !r_rx_s) ? START : IDLE;
            end
            START: if (r_count == HALF) begin
                w_count = '0;
                w_next  = r_rx_s ? IDLE : DATA;
            end
            DATA: if (r_count == LAST) begin
                w_count          = '0;
                w_shift[r_index] = r_rx_s;
                w_index          = r_index + 1'b1;
`ifdef UART_RX_PARITY_EN
                w_next           = (r_index == 3'd7) ? PARITY : DATA;
`else
                w_next           = (r_index == 3'd7) ? STOP : DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (r_count == LAST) begin
                w_count = '0;
                w_par   = r_rx_s;
                w_next  = STOP;
            end
`endif
            STOP: if (r_count == LAST) begin
                w_count = '0;
                w_next  = IDLE;
                w_ferr  = !r_rx_s;
                w_valid = r_rx_s && !w_par_bad;
                w_data  = w_valid ? r_shift : r_data;
`ifdef UART_RX_PARITY_EN
                w_perr  = w_par_bad;
`endif
            end
            default: w_next = IDLE;
        endcase
    end
endmodule
